pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the CPU core. It decides each cycle whether the PC and the p1p2, p2p3 and p3p4 pipeline registers capture, hold or take a bubble. It resolves load-use hazards, taken-branch redirects, data-memory wait states and multi-cycle execute operations, and it keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- STALL_CNT_W, default 16: width of the stall-cycle counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - i_clk  in  1  core clock
  - i_rst_n  in  1  asynchronous active-low reset
- P2 (decode) hazard inputs:
  - i_p2_rs1, i_p2_rs2  in  5 each  source register indices of the instruction in P2
  - i_p2_use_rs1, i_p2_use_rs2  in  1 each  the P2 instruction reads rs1 / rs2
- P3 (execute) inputs:
  - i_p3_rd  in  5  destination register of the instruction in P3
  - i_p3_is_load  in  1  P3 holds a load
  - i_p3_redirect  in  1  P3 branch/jump taken; PC mux selects the target
  - i_p3_mc_start  in  1  P3 holds a multi-cycle op (mul/div)
- Multi-cycle unit and data memory:
  - i_mc_done  in  1  multi-cycle result valid
  - i_dmem_req  in  1  P4 data-memory request active
  - i_dmem_ready  in  1  data memory accepts/completes the request
- Counter control: i_cnt_clr  in  1  synchronous clear of the stall counter
- Enable outputs: o_pc_en, o_p1p2_en, o_p2p3_en, o_p3p4_en  out  1 each  register captures its input
- Flush outputs: o_p1p2_flush, o_p2p3_flush, o_p3p4_flush  out  1 each  register loads a bubble (insn 32'h00000013, ctrl '0); flush overrides en
- Status outputs:
  - o_state  out  2  current FSM state
  - o_stall_cycles  out  STALL_CNT_W  saturating count of cycles with o_pc_en=0

## Operation
- FSM states: RUN=0, MEM_WAIT=1, MC_WAIT=2. Encoding 3 is illegal; it returns to RUN.
- Hazard term: load_use = i_p3_is_load & (i_p3_rd!=0) & ((i_p2_use_rs1 & i_p2_rs1==i_p3_rd) | (i_p2_use_rs2 & i_p2_rs2==i_p3_rd)).
- In RUN, the first matching row applies:
  1. i_dmem_req & ~i_dmem_ready: all enables 0, no flush. Next state MEM_WAIT.
  2. i_p3_redirect: all enables 1; p1p2_flush=1 and p2p3_flush=1. Redirect beats load_use.
  3. i_p3_mc_start: pc/p1p2/p2p3 en=0, p3p4_flush=1. Next state MC_WAIT.
  4. load_use: pc/p1p2 en=0, p2p3_flush=1, p3p4_en=1.
  5. Otherwise: all enables 1, no flush.
- MEM_WAIT:
  - While ~i_dmem_ready, all enables are 0.
  - When i_dmem_ready arrives, the next state is RUN. In that same cycle the outputs are those RUN rows 2–5 would give; a pending redirect or load_use is applied then.
- MC_WAIT:
  - While ~i_mc_done: pc/p1p2/p2p3 en=0, p3p4_flush=1.
  - When i_mc_done arrives: all enables 1, no flush, next state RUN.
  - i_p3_redirect and load_use are ignored in MC_WAIT (P3 holds the mc op).
- i_mc_done in RUN is ignored. i_mc_start is ignored outside RUN.
- Counter:
  - Increments when o_pc_en=0 and stops at all-ones.
  - i_cnt_clr forces 0 and wins over the increment.

## Timing
- Enables and flushes are combinational from the state and inputs, with zero latency. All registers act on the next i_clk edge.
- Reset values: state RUN, o_stall_cycles=0. With the pipeline registers in reset (NOP, no load, no request), outputs are all en=1 and all flush=0.
- A reset mid-wait returns to RUN immediately, asynchronously. No wait state survives reset.
- A load-use stall costs exactly 1 bubble.
- A redirect costs 2 bubbles.
- MEM_WAIT costs N cycles, where N is the number of cycles with ~i_dmem_ready.
- MC_WAIT inserts one p3p4 bubble per cycle until done.
- If a memory wait and a multi-cycle start coincide, the memory wait is served first. i_p3_mc_start stays asserted because P3 is frozen, so MC_WAIT is entered afterwards.

## Structure
- Add to cpu_types.vh:
  - pipe_state_t enum {RUN, MEM_WAIT, MC_WAIT}
  - pipe_ctrl_t packed struct {pc_en, p1p2_en, p1p2_flush, p2p3_en, p2p3_flush, p3p4_en, p3p4_flush}
  - NOP_INSN = 32'h00000013
- Sub-module sat_counter #(W): clear, increment, saturate. It is instantiated once for the stall counter.

## Test plan
- Load x5 in P3, P2 add reads rs1=x5: one cycle with pc_en=0, p2p3_flush=1. The next cycle is all en=1. Counter=1.
- Load to x0 with P2 reading x0: no stall.
- Redirect and load_use in the same cycle: p1p2_flush=p2p3_flush=1, pc_en=1, no stall.
- i_dmem_req with ready low for 3 cycles: state MEM_WAIT for 3 cycles with all en=0. On the ready cycle all en=1. Counter=3.
- i_p3_mc_start, done after 4 cycles: 4 cycles of p3p4_flush=1 with pc_en=0. The done cycle is all en=1 and state returns to RUN.
- Assert i_rst_n low during MC_WAIT: state=0 and counter=0 immediately. Drive the counter to all-ones and keep stalling: it holds at all-ones. Assert i_cnt_clr: it goes to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and decode helpers for the pipeline sequencer.
// Enables and flushes are carried together in pipe_ctrl_t.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MC_WAIT  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic p1p2_en;
        logic p1p2_flush;
        logic p2p3_en;
        logic p2p3_flush;
        logic p3p4_en;
        logic p3p4_flush;
    } pipe_ctrl_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam pipe_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, p1p2_en: 1'b1, p1p2_flush: 1'b0,
                                         p2p3_en: 1'b1, p2p3_flush: 1'b0,
                                         p3p4_en: 1'b1, p3p4_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD = '{default: 1'b0};
    localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, p1p2_en: 1'b1, p1p2_flush: 1'b1,
                                             p2p3_en: 1'b1, p2p3_flush: 1'b1,
                                             p3p4_en: 1'b1, p3p4_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_MC = '{pc_en: 1'b0, p1p2_en: 1'b0, p1p2_flush: 1'b0,
                                       p2p3_en: 1'b0, p2p3_flush: 1'b0,
                                       p3p4_en: 1'b1, p3p4_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, p1p2_en: 1'b0, p1p2_flush: 1'b0,
                                             p2p3_en: 1'b1, p2p3_flush: 1'b1,
                                             p3p4_en: 1'b1, p3p4_flush: 1'b0};

    // P2 reads a register that the load in P3 has not produced yet (x0 never hazards).
    function automatic logic load_use_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic use_rs1, input logic use_rs2,
                                             input logic [4:0] rd, input logic is_load);
        return is_load && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

    // Priority of the non-memory hazards once no memory wait is pending.
    function automatic pipe_ctrl_t run_ctrl(input logic redirect, input logic mc_start,
                                            input logic load_use);
        if (redirect)      return CTRL_REDIRECT;
        else if (mc_start) return CTRL_MC;
        else if (load_use) return CTRL_LOAD_USE;
        else               return CTRL_FLOW;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-cycle enable/flush for PC and pipeline registers,
// wait-state FSM for data memory and multi-cycle ops, and a stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [4:0]             i_p2_rs1,
    input  logic [4:0]             i_p2_rs2,
    input  logic                   i_p2_use_rs1,
    input  logic                   i_p2_use_rs2,
    input  logic [4:0]             i_p3_rd,
    input  logic                   i_p3_is_load,
    input  logic                   i_p3_redirect,
    input  logic                   i_p3_mc_start,
    input  logic                   i_mc_done,
    input  logic                   i_dmem_req,
    input  logic                   i_dmem_ready,
    input  logic                   i_cnt_clr,
    output logic                   o_pc_en,
    output logic                   o_p1p2_en,
    output logic                   o_p2p3_en,
    output logic                   o_p3p4_en,
    output logic                   o_p1p2_flush,
    output logic                   o_p2p3_flush,
    output logic                   o_p3p4_flush,
    output logic [1:0]             o_state,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    pipe_state_t state_q;
    pipe_state_t state_d;
    pipe_ctrl_t  ctrl;
    pipe_ctrl_t  run_rows;
    logic        load_use;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and zero-latency enables/flushes.
    always_comb begin
        state_d  = state_q;
        ctrl     = CTRL_FLOW;
        load_use = load_use_hazard(i_p2_rs1, i_p2_rs2, i_p2_use_rs1, i_p2_use_rs2,
                                   i_p3_rd, i_p3_is_load);
        run_rows = run_ctrl(i_p3_redirect, i_p3_mc_start, load_use);
        case (state_q)
            RUN: begin
                if (i_dmem_req && !i_dmem_ready) begin
                    ctrl    = CTRL_HOLD;
                    state_d = MEM_WAIT;
                end else begin
                    ctrl = run_rows;
                    if (!i_p3_redirect && i_p3_mc_start) begin
                        state_d = MC_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // A still-asserted mc_start re-enters MC_WAIT from RUN next cycle.
                if (!i_dmem_ready) begin
                    ctrl = CTRL_HOLD;
                end else begin
                    ctrl    = run_rows;
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                if (!i_mc_done) begin
                    ctrl = CTRL_MC;
                end else begin
                    ctrl    = CTRL_FLOW;
                    state_d = RUN;
                end
            end
            default: begin
                ctrl    = CTRL_FLOW;
                state_d = RUN;
            end
        endcase
    end

    assign o_pc_en      = ctrl.pc_en;
    assign o_p1p2_en    = ctrl.p1p2_en;
    assign o_p1p2_flush = ctrl.p1p2_flush;
    assign o_p2p3_en    = ctrl.p2p3_en;
    assign o_p2p3_flush = ctrl.p2p3_flush;
    assign o_p3p4_en    = ctrl.p3p4_en;
    assign o_p3p4_flush = ctrl.p3p4_flush;
    assign o_state      = state_q;

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_cnt_clr),
        .i_inc   (!ctrl.pc_en),
        .o_count (o_stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (4-bit stall counter to reach saturation).
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    // Expected control vectors in order {pc_en,p1p2_en,p1p2_flush,p2p3_en,p2p3_flush,p3p4_en,p3p4_flush}
    localparam logic [6:0] E_ALL   = 7'b1101010;
    localparam logic [6:0] E_HOLD  = 7'b0000000;
    localparam logic [6:0] E_REDIR = 7'b1111110;
    localparam logic [6:0] E_MC    = 7'b0000011;
    localparam logic [6:0] E_LU    = 7'b0001110;
    localparam logic [1:0] S_RUN = 2'd0, S_MEM = 2'd1, S_MC = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic use1 = 0, use2 = 0, is_load = 0, redir = 0, mc_start = 0, mc_done = 0;
    logic req = 0, rdy = 0, clr = 0;

    logic pc_en, p1p2_en, p2p3_en, p3p4_en, p1p2_fl, p2p3_fl, p3p4_fl;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic use1, use2, is_load, redir, mc_start, mc_done, req, rdy, clr, rst_n;
    } vec_t;

    typedef struct {
        logic [6:0]    ctrl;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        string         nm;
    } exp_t;

    exp_t q[$];
    vec_t v;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_p2_rs1       (rs1),
        .i_p2_rs2       (rs2),
        .i_p2_use_rs1   (use1),
        .i_p2_use_rs2   (use2),
        .i_p3_rd        (rd),
        .i_p3_is_load   (is_load),
        .i_p3_redirect  (redir),
        .i_p3_mc_start  (mc_start),
        .i_mc_done      (mc_done),
        .i_dmem_req     (req),
        .i_dmem_ready   (rdy),
        .i_cnt_clr      (clr),
        .o_pc_en        (pc_en),
        .o_p1p2_en      (p1p2_en),
        .o_p2p3_en      (p2p3_en),
        .o_p3p4_en      (p3p4_en),
        .o_p1p2_flush   (p1p2_fl),
        .o_p2p3_flush   (p2p3_fl),
        .o_p3p4_flush   (p3p4_fl),
        .o_state        (state),
        .o_stall_cycles (cnt)
    );

    task automatic idle();
        v = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, use1: 1'b0, use2: 1'b0, is_load: 1'b0,
              redir: 1'b0, mc_start: 1'b0, mc_done: 1'b0, req: 1'b0, rdy: 1'b0,
              clr: 1'b0, rst_n: 1'b1};
    endtask

    // Apply v for one cycle and queue the response expected during that cycle.
    task automatic step(input logic [6:0] ec, input logic [1:0] es, input int ecnt,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; use1 = v.use1; use2 = v.use2;
        is_load = v.is_load; redir = v.redir; mc_start = v.mc_start; mc_done = v.mc_done;
        req = v.req; rdy = v.rdy; clr = v.clr; rst_n = v.rst_n;
        e.ctrl = ec; e.st = es; e.cnt = CW'(ecnt); e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_en, p1p2_en, p1p2_fl, p2p3_en, p2p3_fl, p3p4_en, p3p4_fl};
                n_run += 3;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL %s ctrl: got %b expected %b", e.nm, act, e.ctrl);
                end
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
                end
                if (cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s count: got %0d expected %0d", e.nm, cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        idle(); step(E_ALL, S_RUN, 0, "reset_idle");

        // Load-use on rs1: one bubble, then flow
        idle(); v.is_load = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.use1 = 1;
        step(E_LU, S_RUN, 0, "lu_rs1");
        idle(); step(E_ALL, S_RUN, 1, "lu_after");
        idle(); v.is_load = 1; v.rd = 5'd0; v.rs1 = 5'd0; v.use1 = 1;
        step(E_ALL, S_RUN, 1, "lu_x0");
        idle(); v.is_load = 1; v.rd = 5'd7; v.rs1 = 5'd7; v.use1 = 0;
        step(E_ALL, S_RUN, 1, "lu_unused_rs1");
        idle(); v.is_load = 1; v.rd = 5'd7; v.rs2 = 5'd7; v.use2 = 1;
        step(E_LU, S_RUN, 1, "lu_rs2");
        idle(); step(E_ALL, S_RUN, 2, "lu_rs2_after");

        // Redirect beats load-use
        idle(); v.redir = 1; v.is_load = 1; v.rd = 5'd9; v.rs1 = 5'd9; v.use1 = 1;
        step(E_REDIR, S_RUN, 2, "redir_lu");
        idle(); v.clr = 1; step(E_ALL, S_RUN, 2, "clr1");

        // Memory wait of 3 cycles
        idle(); v.req = 1; step(E_HOLD, S_RUN, 0, "mem_w0");
        idle(); v.req = 1; step(E_HOLD, S_MEM, 1, "mem_w1");
        idle(); v.req = 1; step(E_HOLD, S_MEM, 2, "mem_w2");
        idle(); v.req = 1; v.rdy = 1; step(E_ALL, S_MEM, 3, "mem_ready");
        idle(); step(E_ALL, S_RUN, 3, "mem_done");

        // Load-use pending when memory becomes ready
        idle(); v.req = 1; step(E_HOLD, S_RUN, 3, "mem_lu_w");
        idle(); v.req = 1; v.rdy = 1; v.is_load = 1; v.rd = 5'd3; v.rs2 = 5'd3; v.use2 = 1;
        step(E_LU, S_MEM, 4, "mem_lu_ready");
        idle(); step(E_ALL, S_RUN, 5, "mem_lu_after");

        // Memory wait coinciding with a multi-cycle start
        idle(); v.req = 1; v.mc_start = 1; step(E_HOLD, S_RUN, 5, "co_w");
        idle(); v.req = 1; v.rdy = 1; v.mc_start = 1; step(E_MC, S_MEM, 6, "co_ready");
        idle(); v.mc_start = 1; step(E_MC, S_RUN, 7, "co_mc_start");
        idle(); v.mc_done = 1; step(E_ALL, S_MC, 8, "co_mc_done");
        idle(); v.clr = 1; step(E_ALL, S_RUN, 8, "clr2");

        // Multi-cycle op, done after 4 bubbles; redirect/load-use ignored while waiting
        idle(); v.mc_start = 1; step(E_MC, S_RUN, 0, "mc_start");
        idle(); v.redir = 1; v.is_load = 1; v.rd = 5'd4; v.rs1 = 5'd4; v.use1 = 1;
        step(E_MC, S_MC, 1, "mc_w1_ignore");
        idle(); step(E_MC, S_MC, 2, "mc_w2");
        idle(); v.mc_start = 1; step(E_MC, S_MC, 3, "mc_w3");
        idle(); v.mc_done = 1; step(E_ALL, S_MC, 4, "mc_done");
        idle(); v.mc_done = 1; step(E_ALL, S_RUN, 4, "mc_done_in_run");

        // Asynchronous reset in the middle of MC_WAIT
        idle(); v.mc_start = 1; step(E_MC, S_RUN, 4, "rst_mc_start");
        idle(); v.rst_n = 0; step(E_ALL, S_RUN, 0, "rst_async");
        idle(); step(E_ALL, S_RUN, 0, "rst_release");

        // Saturation, then clear winning over a stall
        for (int i = 0; i < 18; i++) begin
            idle(); v.req = 1;
            step(E_HOLD, (i == 0) ? S_RUN : S_MEM, (i > 15) ? 15 : i, "sat");
        end
        idle(); v.req = 1; v.clr = 1; step(E_HOLD, S_MEM, 15, "sat_clr");
        idle(); v.req = 1; v.rdy = 1; step(E_ALL, S_MEM, 0, "after_clr");
        idle(); step(E_ALL, S_RUN, 0, "final");

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
